// File: rtl/median_frame_sequencer.sv
// Frame sequencer for the streaming 3x3 median filter: reads one frame from the input RAM into
// the filter, flushes the filter pipeline and writes every output sample, in order, to the output RAM.
module median_frame_sequencer #(
  parameter int unsigned WIDTH    = 256,
  parameter int unsigned HEIGHT   = 256,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned FILT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              filt_rst,
  output logic [7:0]        filt_pixel,
  input  logic [7:0]        filt_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam int unsigned N        = WIDTH * HEIGHT;
  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned LAT_W    = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
  localparam int unsigned LAT_LAST = FILT_LAT - 1;

  localparam logic [ADDR_W:0]   N_L        = N[ADDR_W:0];
  localparam logic [ADDR_W:0]   ZERO_C     = CNT_W'(1'b0);
  localparam logic [ADDR_W:0]   ONE_C      = CNT_W'(1'b1);
  localparam logic [ADDR_W:0]   TWO_C      = CNT_W'(2'd2);
  localparam logic [ADDR_W:0]   LAST_PIX   = N_L - ONE_C;
  localparam logic [LAT_W-1:0]  LAT_ZERO   = LAT_W'(1'b0);
  localparam logic [LAT_W-1:0]  LAT_ONE    = LAT_W'(1'b1);
  localparam logic [LAT_W-1:0]  LAT_LAST_L = LAT_LAST[LAT_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = ADDR_W'(1'b0);

  state_e state_q, state_d;

  logic [ADDR_W:0]   pix_cnt_q, pix_cnt_d;
  logic [LAT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              filt_rst_q, filt_rst_d;

  // Write delay line: stage k holds the pixel index presented k+1 cycles ago.
  logic [FILT_LAT-1:0]             dl_vld_q, dl_vld_d;
  logic [FILT_LAT-1:0][ADDR_W-1:0] dl_idx_q, dl_idx_d;

  logic            abort_hit;
  logic            pix_last;
  logic            flush_last;
  logic [ADDR_W:0] rd_next;

  assign abort_hit  = abort && ((state_q == S_CLEAR) || (state_q == S_STREAM) || (state_q == S_FLUSH));
  assign pix_last   = (pix_cnt_q == LAST_PIX);
  assign flush_last = (flush_cnt_q == LAT_LAST_L);
  assign rd_next    = pix_cnt_q + TWO_C;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
        else       state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (abort_hit) state_d = S_IDLE;
        else           state_d = S_STREAM;
      end
      S_STREAM: begin
        if (abort_hit)     state_d = S_IDLE;
        else if (pix_last) state_d = S_FLUSH;
        else               state_d = S_STREAM;
      end
      S_FLUSH: begin
        if (abort_hit)       state_d = S_IDLE;
        else if (flush_last) state_d = S_DONE;
        else                 state_d = S_FLUSH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    filt_rst_d = filt_rst_q;
    if ((state_q == S_FLUSH) && (state_d == S_DONE)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_en_d    = 1'b1;
          rd_addr_d  = ADDR_ZERO;
          filt_rst_d = 1'b1;
        end else begin
          filt_rst_d = filt_rst_q;
        end
      end
      S_CLEAR: begin
        if (abort_hit) begin
          rd_addr_d  = ADDR_ZERO;
          filt_rst_d = 1'b1;
        end else begin
          rd_en_d    = (ONE_C < N_L);
          rd_addr_d  = ONE_C[ADDR_W-1:0];
          filt_rst_d = 1'b0;
        end
      end
      S_STREAM: begin
        if (abort_hit) begin
          rd_addr_d  = ADDR_ZERO;
          filt_rst_d = 1'b1;
        end else if (rd_next < N_L) begin
          rd_en_d    = 1'b1;
          rd_addr_d  = rd_next[ADDR_W-1:0];
          filt_rst_d = 1'b0;
        end else begin
          filt_rst_d = 1'b0;
        end
      end
      S_FLUSH: begin
        if (abort_hit) begin
          rd_addr_d  = ADDR_ZERO;
          filt_rst_d = 1'b1;
        end else begin
          filt_rst_d = 1'b0;
        end
      end
      S_DONE: filt_rst_d = 1'b0;
      default: begin
        rd_addr_d  = ADDR_ZERO;
        filt_rst_d = 1'b1;
      end
    endcase
  end

  // Pixel and flush counters, both reset on entry to their state.
  always_comb begin
    if (state_q == S_STREAM) pix_cnt_d = pix_cnt_q + ONE_C;
    else                     pix_cnt_d = ZERO_C;
    if (state_q == S_FLUSH)  flush_cnt_d = flush_cnt_q + LAT_ONE;
    else                     flush_cnt_d = LAT_ZERO;
  end

  // Delay line fed from STREAM; an abort empties it so no late writes escape.
  always_comb begin
    dl_vld_d = dl_vld_q;
    dl_idx_d = dl_idx_q;
    if (abort_hit) begin
      dl_vld_d = {FILT_LAT{1'b0}};
    end else begin
      dl_vld_d[0] = (state_q == S_STREAM);
      dl_idx_d[0] = pix_cnt_q[ADDR_W-1:0];
      for (int k = 1; k < FILT_LAT; k++) begin
        dl_vld_d[k] = dl_vld_q[k-1];
        dl_idx_d[k] = dl_idx_q[k-1];
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_q   <= ZERO_C;
      flush_cnt_q <= LAT_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= ADDR_ZERO;
      filt_rst_q  <= 1'b1;
      dl_vld_q    <= {FILT_LAT{1'b0}};
      dl_idx_q    <= {(FILT_LAT*ADDR_W){1'b0}};
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      filt_rst_q  <= filt_rst_d;
      dl_vld_q    <= dl_vld_d;
      dl_idx_q    <= dl_idx_d;
    end
  end

  // RAM read data goes straight to the filter so pixel i lands in cycle 2+i.
  assign filt_pixel = (state_q == S_STREAM) ? rd_data : 8'd0;
  assign wr_en      = dl_vld_q[FILT_LAT-1];
  assign wr_addr    = dl_idx_q[FILT_LAT-1];
  assign wr_data    = wr_en ? filt_out : 8'd0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign filt_rst  = filt_rst_q;

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Bench for median_frame_sequencer: two instances (filter latency 1 and 3) driven by the same
// start/abort/rst stream, checked each cycle against a frame-timeline model.
module tb_median_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic start, abort, rst;

  logic          busy_a [2];
  logic          done_a [2];
  logic [15:0]   frame_cnt_a [2];
  logic          rd_en_a [2];
  logic [AW-1:0] rd_addr_a [2];
  logic [7:0]    rd_data_a [2];
  logic          filt_rst_a [2];
  logic [7:0]    filt_pixel_a [2];
  logic [7:0]    filt_out_a [2];
  logic          wr_en_a [2];
  logic [AW-1:0] wr_addr_a [2];
  logic [7:0]    wr_data_a [2];

  logic [7:0] in_ram [N];
  logic [7:0] out_ram [2][N];
  logic [7:0] sr [2][3];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    median_frame_sequencer #(
      .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .FILT_LAT((g == 0) ? 1 : 3)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .busy(busy_a[g]), .done(done_a[g]), .frame_cnt(frame_cnt_a[g]),
      .rd_en(rd_en_a[g]), .rd_addr(rd_addr_a[g]), .rd_data(rd_data_a[g]),
      .filt_rst(filt_rst_a[g]), .filt_pixel(filt_pixel_a[g]), .filt_out(filt_out_a[g]),
      .wr_en(wr_en_a[g]), .wr_addr(wr_addr_a[g]), .wr_data(wr_data_a[g])
    );
  end

  // Input RAM, output RAM and a pure-delay filter stub per instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en_a[k] && (rd_addr_a[k] < AW'(N))) rd_data_a[k] <= in_ram[rd_addr_a[k][3:0]];
      if (wr_en_a[k] && (wr_addr_a[k] < AW'(N))) out_ram[k][wr_addr_a[k][3:0]] <= wr_data_a[k];
      if (filt_rst_a[k]) begin
        for (int j = 0; j < 3; j++) sr[k][j] <= 8'd0;
      end else begin
        sr[k][0] <= filt_pixel_a[k];
        sr[k][1] <= sr[k][0];
        sr[k][2] <= sr[k][1];
      end
    end
  end
  assign filt_out_a[0] = sr[0][0];
  assign filt_out_a[1] = sr[1][2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: per instance, whether a frame is running and t = cycles since start was sampled.
  bit act [2];
  int t   [2];
  int cnt [2];
  bit frst[2];
  bit ok   = 1'b0;
  bit rchk = 1'b0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      int L = lat_of(k);
      string p = $sformatf("u%0d", k);
      bit e_done = act[k] && (t[k] == N + 2 + L);
      bit e_rd   = act[k] && (t[k] >= 1) && (t[k] <= N);
      bit e_wr   = act[k] && (t[k] >= 2 + L) && (t[k] <= N + 1 + L);
      bit e_frst = act[k] ? (t[k] == 1) : frst[k];
      if (ok) begin
        check_eq({p, " busy"}, 32'(busy_a[k]), 32'(act[k]));
        check_eq({p, " done"}, 32'(done_a[k]), 32'(e_done));
        check_eq({p, " rd_en"}, 32'(rd_en_a[k]), 32'(e_rd));
        check_eq({p, " wr_en"}, 32'(wr_en_a[k]), 32'(e_wr));
        check_eq({p, " filt_rst"}, 32'(filt_rst_a[k]), 32'(e_frst));
        check_eq({p, " frame_cnt"}, 32'(frame_cnt_a[k]), 32'(cnt[k] & 16'hFFFF));
        if (e_rd) check_eq({p, " rd_addr"}, 32'(rd_addr_a[k]), 32'(t[k] - 1));
        if (e_wr) begin
          check_eq({p, " wr_addr"}, 32'(wr_addr_a[k]), 32'(t[k] - 2 - L));
          check_eq({p, " wr_data"}, 32'(wr_data_a[k]), 32'(in_ram[t[k] - 2 - L]));
        end
        if (act[k] && (t[k] >= 2) && (t[k] <= N + 1))
          check_eq({p, " pixel"}, 32'(filt_pixel_a[k]), 32'(in_ram[t[k] - 2]));
        if (act[k] && (t[k] >= N + 2) && (t[k] <= N + 1 + L))
          check_eq({p, " flush pixel"}, 32'(filt_pixel_a[k]), 32'd0);
        if (rchk) begin
          check_eq({p, " rst rd_addr"}, 32'(rd_addr_a[k]), 32'd0);
          check_eq({p, " rst wr_addr"}, 32'(wr_addr_a[k]), 32'd0);
          check_eq({p, " rst wr_data"}, 32'(wr_data_a[k]), 32'd0);
          check_eq({p, " rst pixel"}, 32'(filt_pixel_a[k]), 32'd0);
        end
        if (e_done) begin
          for (int i = 0; i < N; i++)
            check_eq($sformatf("%s out_ram[%0d]", p, i), 32'(out_ram[k][i]), 32'(in_ram[i]));
        end
      end
    end
  endtask

  task automatic advance(input bit st, input bit ab, input bit rs);
    for (int k = 0; k < 2; k++) begin
      int L = lat_of(k);
      if (rs) begin
        act[k] = 1'b0; cnt[k] = 0; frst[k] = 1'b1;
      end else if (!act[k]) begin
        if (st) begin act[k] = 1'b1; t[k] = 1; end
      end else if (t[k] == N + 2 + L) begin
        act[k] = 1'b0; frst[k] = 1'b0;
      end else if (ab) begin
        act[k] = 1'b0; frst[k] = 1'b1;
      end else begin
        t[k]++;
        if (t[k] == N + 2 + L) cnt[k]++;
      end
    end
    if (rs) ok = 1'b1;
    rchk = rs;
  endtask

  task automatic step(input bit st, input bit ab, input bit rs);
    start = st; abort = ab; rst = rs;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    advance(st, ab, rs);
    cyc++;
    #1;
  endtask

  task automatic drain_and_refill();
    for (int j = 0; j < 60 && (act[0] || act[1]); j++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) in_ram[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin act[k] = 1'b0; t[k] = 0; cnt[k] = 0; frst[k] = 1'b1; end
    for (int i = 0; i < N; i++) in_ram[i] = 8'(i * 10);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Single frame with the ramp image.
    step(1'b1, 1'b0, 1'b0);
    repeat (24) step(1'b0, 1'b0, 1'b0);
    drain_and_refill();

    // start held high: back-to-back frames, mid-frame start ignored.
    repeat (40) step(1'b1, 1'b0, 1'b0);
    drain_and_refill();

    // Abort in cycle 6.
    step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    drain_and_refill();

    // rst in cycle 8, then a clean frame.
    for (int j = 0; j < 40; j++) step((j == 0) || (j == 12), 1'b0, j == 8);
    drain_and_refill();

    // Random start/abort/rst traffic.
    for (int b = 0; b < 4; b++) begin
      repeat (150) step(($urandom % 4) == 0, ($urandom % 12) == 0, ($urandom % 80) == 0);
      drain_and_refill();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
